// File: rtl/regfile_port_scheduler.sv
// Register-file and rename-tag-table write-port scheduler.
// Arbitrates queued ROB commits, decoder renames and a flush walk.
module regfile_port_scheduler #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 5,
  parameter int          TAG_W     = 5,
  parameter logic [4:0]  EMPTY_TAG = 5'h10,
  parameter int          CQ_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              commit_valid,
  output logic              commit_ready,
  input  logic [ADDR_W-1:0] commit_addr,
  input  logic [DATA_W-1:0] commit_value,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic              rename_valid,
  output logic              rename_ready,
  input  logic [ADDR_W-1:0] rename_addr,
  input  logic [TAG_W-1:0]  rename_tag,
  output logic              flush_busy,
  output logic [ADDR_W-1:0] tag_raddr,
  input  logic [TAG_W-1:0]  tag_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              tag_we,
  output logic [ADDR_W-1:0] tag_waddr,
  output logic [TAG_W-1:0]  tag_wdata
);

  localparam int PW = $clog2(CQ_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [ADDR_W-1:0] cq_addr_q  [CQ_DEPTH];
  logic [DATA_W-1:0] cq_value_q [CQ_DEPTH];
  logic [TAG_W-1:0]  cq_tag_q   [CQ_DEPTH];

  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_value;
  logic [TAG_W-1:0]  head_tag;

  logic push;
  logic pop;
  logic is_flush;
  logic rename_acc;
  logic needs_clear;
  logic tag_busy;

  assign head_addr  = cq_addr_q[head_q];
  assign head_value = cq_value_q[head_q];
  assign head_tag   = cq_tag_q[head_q];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    commit_ready = 1'b0;
    rename_ready = 1'b0;
    flush_busy   = 1'b0;
    tag_raddr    = '0;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    tag_we       = 1'b0;
    tag_waddr    = '0;
    tag_wdata    = '0;
    push         = 1'b0;
    pop          = 1'b0;
    is_flush     = 1'b0;
    rename_acc   = 1'b0;
    needs_clear  = 1'b0;
    tag_busy     = 1'b0;
    if (!rst) begin
      is_flush     = (state_q == FLUSH);
      flush_busy   = is_flush;
      tag_raddr    = head_addr;
      commit_ready = rdy && (count_q < CW'(CQ_DEPTH));
      rename_ready = rdy && !is_flush && !clr;
      push         = commit_valid && commit_ready;
      rename_acc   = rename_valid && rename_ready;
      needs_clear  = (head_addr != '0) && (tag_rdata == head_tag);
      if (rdy && is_flush) begin
        tag_we    = 1'b1;
        tag_waddr = cnt_q;
        tag_wdata = TAG_W'(EMPTY_TAG);
      end else if (rename_acc && rename_addr != '0) begin
        tag_we    = 1'b1;
        tag_waddr = rename_addr;
        tag_wdata = rename_tag;
      end
      tag_busy = tag_we;
      // A rename of the head register makes the clear redundant
      if (rdy && count_q != '0) begin
        pop = !needs_clear || is_flush || !tag_busy ||
              (rename_acc && rename_addr == head_addr);
      end
      if (pop && head_addr != '0) begin
        rf_we    = 1'b1;
        rf_waddr = head_addr;
        rf_wdata = head_value;
      end
      if (pop && needs_clear && !is_flush && !tag_busy) begin
        tag_we    = 1'b1;
        tag_waddr = head_addr;
        tag_wdata = TAG_W'(EMPTY_TAG);
      end
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      if (rdy) begin
        if (clr) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (is_flush) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; count_q qualifies every read
  always_ff @(posedge clk) begin
    if (push) begin
      cq_addr_q[tail_q]  <= commit_addr;
      cq_value_q[tail_q] <= commit_value;
      cq_tag_q[tail_q]   <= commit_tag;
    end
  end

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Self-checking bench for regfile_port_scheduler.
// Vector table for single-commit cases plus flush/full/reset sequences.
module tb_regfile_port_scheduler;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TW = 5;

  logic          clk;
  logic          rst;
  logic          rdy;
  logic          clr;
  logic          commit_valid;
  logic          commit_ready;
  logic [AW-1:0] commit_addr;
  logic [DW-1:0] commit_value;
  logic [TW-1:0] commit_tag;
  logic          rename_valid;
  logic          rename_ready;
  logic [AW-1:0] rename_addr;
  logic [TW-1:0] rename_tag;
  logic          flush_busy;
  logic [AW-1:0] tag_raddr;
  logic [TW-1:0] tag_rdata;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          tag_we;
  logic [AW-1:0] tag_waddr;
  logic [TW-1:0] tag_wdata;

  regfile_port_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .clr          (clr),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .commit_addr  (commit_addr),
    .commit_value (commit_value),
    .commit_tag   (commit_tag),
    .rename_valid (rename_valid),
    .rename_ready (rename_ready),
    .rename_addr  (rename_addr),
    .rename_tag   (rename_tag),
    .flush_busy   (flush_busy),
    .tag_raddr    (tag_raddr),
    .tag_rdata    (tag_rdata),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .tag_we       (tag_we),
    .tag_waddr    (tag_waddr),
    .tag_wdata    (tag_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] val;
    logic [TW-1:0] tag;
    logic [TW-1:0] rdata;
    logic          rv;
    logic [AW-1:0] raddr;
    logic [TW-1:0] rtag;
    logic          rf1;
    logic          tw1;
    logic [AW-1:0] ta1;
    logic [TW-1:0] td1;
    logic          rf2;
    logic          tw2;
    logic [AW-1:0] ta2;
    logic [TW-1:0] td2;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] v;
  } rfw_t;

  vec_t vecs [7];
  rfw_t sb [$];
  rfw_t exp_w;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard: accepted commits queue expected rf writes
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (rf_we) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rf_unexpected: got write addr %0h data %0h expected none",
                   rf_waddr, rf_wdata);
        end else begin
          exp_w = sb.pop_front();
          chk("rf_waddr", 64'(rf_waddr), 64'(exp_w.a));
          chk("rf_wdata", 64'(rf_wdata), 64'(exp_w.v));
        end
      end
      if (commit_valid && commit_ready && commit_addr != '0)
        sb.push_back('{commit_addr, commit_value});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int mcnt;
    vecs[0] = '{5'd5, 32'hDEAD, 5'd3, 5'd3, 1'b0, 5'd0, 5'd0,
                1'b1, 1'b1, 5'd5, 5'h10, 1'b0, 1'b0, 5'd0, 5'd0};
    vecs[1] = '{5'd5, 32'hDEAD, 5'd3, 5'd7, 1'b0, 5'd0, 5'd0,
                1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0};
    vecs[2] = '{5'd5, 32'hBEEF, 5'd3, 5'd3, 1'b1, 5'd9, 5'd4,
                1'b0, 1'b1, 5'd9, 5'd4, 1'b1, 1'b1, 5'd5, 5'h10};
    vecs[3] = '{5'd5, 32'hCAFE, 5'd3, 5'd3, 1'b1, 5'd5, 5'd6,
                1'b1, 1'b1, 5'd5, 5'd6, 1'b0, 1'b0, 5'd0, 5'd0};
    vecs[4] = '{5'd0, 32'h1234, 5'd3, 5'd3, 1'b0, 5'd0, 5'd0,
                1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0};
    vecs[5] = '{5'd7, 32'h7777, 5'd3, 5'd3, 1'b1, 5'd0, 5'd2,
                1'b1, 1'b1, 5'd7, 5'h10, 1'b0, 1'b0, 5'd0, 5'd0};
    vecs[6] = '{5'd8, 32'h8888, 5'd2, 5'd1, 1'b1, 5'd9, 5'hA,
                1'b1, 1'b1, 5'd9, 5'hA, 1'b0, 1'b0, 5'd0, 5'd0};

    rst          = 1'b1;
    rdy          = 1'b1;
    clr          = 1'b0;
    commit_valid = 1'b1;
    commit_addr  = 5'd5;
    commit_value = 32'hDEAD;
    commit_tag   = 5'd3;
    rename_valid = 1'b1;
    rename_addr  = 5'd9;
    rename_tag   = 5'd1;
    tag_rdata    = 5'd3;

    repeat (2) sample();
    chk("rst_commit_ready", 64'(commit_ready), 64'd0);
    chk("rst_rename_ready", 64'(rename_ready), 64'd0);
    chk("rst_flush_busy", 64'(flush_busy), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_tag_we", 64'(tag_we), 64'd0);
    chk("rst_tag_raddr", 64'(tag_raddr), 64'd0);

    step();
    rst          = 1'b0;
    commit_valid = 1'b0;
    rename_valid = 1'b0;
    tag_rdata    = '0;
    sample();
    chk("idle_commit_ready", 64'(commit_ready), 64'd1);
    chk("idle_rename_ready", 64'(rename_ready), 64'd1);
    chk("idle_flush_busy", 64'(flush_busy), 64'd0);

    for (int i = 0; i < 7; i++) begin
      step();
      commit_valid = 1'b1;
      commit_addr  = vecs[i].addr;
      commit_value = vecs[i].val;
      commit_tag   = vecs[i].tag;
      tag_rdata    = vecs[i].rdata;
      rename_valid = 1'b0;
      step();
      commit_valid = 1'b0;
      rename_valid = vecs[i].rv;
      rename_addr  = vecs[i].raddr;
      rename_tag   = vecs[i].rtag;
      sample();
      chk($sformatf("v%0d_rename_ready", i), 64'(rename_ready), 64'd1);
      chk($sformatf("v%0d_rf_we", i), 64'(rf_we), 64'(vecs[i].rf1));
      chk($sformatf("v%0d_tag_we", i), 64'(tag_we), 64'(vecs[i].tw1));
      if (vecs[i].tw1) begin
        chk($sformatf("v%0d_tag_waddr", i), 64'(tag_waddr), 64'(vecs[i].ta1));
        chk($sformatf("v%0d_tag_wdata", i), 64'(tag_wdata), 64'(vecs[i].td1));
      end
      step();
      rename_valid = 1'b0;
      sample();
      chk($sformatf("v%0d_rf_we2", i), 64'(rf_we), 64'(vecs[i].rf2));
      chk($sformatf("v%0d_tag_we2", i), 64'(tag_we), 64'(vecs[i].tw2));
      if (vecs[i].tw2) begin
        chk($sformatf("v%0d_tag_waddr2", i), 64'(tag_waddr), 64'(vecs[i].ta2));
        chk($sformatf("v%0d_tag_wdata2", i), 64'(tag_wdata), 64'(vecs[i].td2));
      end
    end

    // Flush walk with two commits in flight
    step();
    commit_valid = 1'b1;
    commit_addr  = 5'd3;
    commit_value = 32'h33;
    commit_tag   = 5'd1;
    tag_rdata    = 5'd0;
    step();
    commit_addr  = 5'd4;
    commit_value = 32'h44;
    commit_tag   = 5'd2;
    clr          = 1'b1;
    rename_valid = 1'b1;
    rename_addr  = 5'd12;
    rename_tag   = 5'd1;
    sample();
    chk("clr_rename_ready", 64'(rename_ready), 64'd0);
    step();
    commit_valid = 1'b0;
    clr          = 1'b0;
    tag_rdata    = 5'd2;
    for (int i = 0; i < 32; i++) begin
      sample();
      chk($sformatf("fl%0d_busy", i), 64'(flush_busy), 64'd1);
      chk($sformatf("fl%0d_tag_we", i), 64'(tag_we), 64'd1);
      chk($sformatf("fl%0d_tag_waddr", i), 64'(tag_waddr), 64'(i));
      chk($sformatf("fl%0d_tag_wdata", i), 64'(tag_wdata), 64'h10);
      chk($sformatf("fl%0d_rename_ready", i), 64'(rename_ready), 64'd0);
      step();
    end
    rename_valid = 1'b0;
    sample();
    chk("fl_done_busy", 64'(flush_busy), 64'd0);
    chk("fl_done_tag_we", 64'(tag_we), 64'd0);
    chk("fl_drained", 64'(sb.size()), 64'd0);

    // Fill the queue while the head stalls behind a competing rename
    step();
    tag_rdata    = 5'd5;
    rename_valid = 1'b1;
    rename_addr  = 5'd9;
    rename_tag   = 5'd3;
    commit_valid = 1'b1;
    commit_addr  = 5'd6;
    commit_tag   = 5'd5;
    mcnt         = 0;
    for (int i = 0; i < 5; i++) begin
      commit_value = 32'h100 + 32'(i);
      sample();
      chk($sformatf("full%0d_commit_ready", i), 64'(commit_ready),
          64'(mcnt < 4));
      chk($sformatf("full%0d_rf_we", i), 64'(rf_we), 64'd0);
      if (mcnt < 4) mcnt++;
      step();
    end
    commit_valid = 1'b0;
    rdy          = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk($sformatf("frz%0d_rf_we", i), 64'(rf_we), 64'd0);
      chk($sformatf("frz%0d_tag_we", i), 64'(tag_we), 64'd0);
      chk($sformatf("frz%0d_commit_ready", i), 64'(commit_ready), 64'd0);
      chk($sformatf("frz%0d_rename_ready", i), 64'(rename_ready), 64'd0);
      step();
    end
    rdy          = 1'b1;
    rename_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk($sformatf("drn%0d_rf_we", i), 64'(rf_we), 64'd1);
      chk($sformatf("drn%0d_tag_we", i), 64'(tag_we), 64'd1);
      chk($sformatf("drn%0d_tag_waddr", i), 64'(tag_waddr), 64'd6);
      chk($sformatf("drn%0d_tag_wdata", i), 64'(tag_wdata), 64'h10);
      step();
    end
    sample();
    chk("drn_empty_rf_we", 64'(rf_we), 64'd0);
    chk("drn_commit_ready", 64'(commit_ready), 64'd1);
    chk("drn_sb_empty", 64'(sb.size()), 64'd0);

    // Freeze mid-flush, then reset with an entry queued
    step();
    clr = 1'b1;
    sample();
    step();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk($sformatf("mf%0d_tag_waddr", i), 64'(tag_waddr), 64'(i));
      step();
    end
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk($sformatf("mfz%0d_tag_we", i), 64'(tag_we), 64'd0);
      chk($sformatf("mfz%0d_busy", i), 64'(flush_busy), 64'd1);
      step();
    end
    rdy          = 1'b1;
    commit_valid = 1'b1;
    commit_addr  = 5'd7;
    commit_value = 32'h77;
    commit_tag   = 5'd0;
    tag_rdata    = 5'd1;
    sample();
    chk("mf_resume_tag_waddr", 64'(tag_waddr), 64'd5);
    step();
    commit_valid = 1'b0;
    rst          = 1'b1;
    sample();
    chk("mrst_busy", 64'(flush_busy), 64'd0);
    chk("mrst_tag_we", 64'(tag_we), 64'd0);
    chk("mrst_rf_we", 64'(rf_we), 64'd0);
    chk("mrst_commit_ready", 64'(commit_ready), 64'd0);
    chk("mrst_tag_raddr", 64'(tag_raddr), 64'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk($sformatf("post%0d_rf_we", i), 64'(rf_we), 64'd0);
      chk($sformatf("post%0d_busy", i), 64'(flush_busy), 64'd0);
      chk($sformatf("post%0d_tag_we", i), 64'(tag_we), 64'd0);
      step();
    end
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
